// File: rtl/calc_pkg.sv
// Shared definitions for the serial calculator: opcodes, FSM states,
// and the position of the chain flag inside the opcode word.
package calc_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_SQR = 4'd3;
  localparam logic [3:0] OP_DIV = 4'd4;
  localparam logic [3:0] OP_MOD = 4'd5;
  localparam logic [3:0] OP_AND = 4'd6;
  localparam logic [3:0] OP_OR  = 4'd7;
  localparam logic [3:0] OP_XOR = 4'd8;

  localparam int CHAIN_BIT = 4;

  typedef enum logic [2:0] {
    S_A,
    S_OP,
    S_B,
    S_DIV,
    S_RES
  } state_t;

  function automatic logic op_legal(input logic [3:0] op);
    return op <= OP_XOR;
  endfunction

endpackage

// File: rtl/calc_if.sv
// Input word stream and result stream of the calculator.
// master = host/sink side, slave = calculator side.
interface calc_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dataIn;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             ovf;
  logic             err;

  modport master (
    output in_valid, dataIn, out_ready,
    input  in_ready, out_valid, out, ovf, err
  );

  modport slave (
    input  in_valid, dataIn, out_ready,
    output in_ready, out_valid, out, ovf, err
  );

endinterface

// File: rtl/calc_div.sv
// Restoring divider, one quotient bit per clock; the first bit
// is produced on the start edge so the whole run takes WIDTH edges.
module calc_div #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] r_r, r_q, r_d;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] src_r, src_q, src_d;
  logic [WIDTH-1:0] nxt_r, nxt_q;
  logic [WIDTH:0]   trial;

  always_comb begin
    src_r = start ? '0 : r_r;
    src_q = start ? dividend : r_q;
    src_d = start ? divisor : r_d;
    trial = {src_r, src_q[WIDTH-1]} - {1'b0, src_d};
    if (!trial[WIDTH]) begin
      nxt_r = trial[WIDTH-1:0];
      nxt_q = {src_q[WIDTH-2:0], 1'b1};
    end else begin
      nxt_r = {src_r[WIDTH-2:0], src_q[WIDTH-1]};
      nxt_q = {src_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_r  <= '0;
      r_q  <= '0;
      r_d  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        r_r  <= nxt_r;
        r_q  <= nxt_q;
        r_d  <= divisor;
        cnt  <= CW'(WIDTH - 1);
        busy <= 1'b1;
      end else if (busy) begin
        r_r <= nxt_r;
        r_q <= nxt_q;
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign quot = r_q;
  assign rem  = r_r;

endmodule

// File: rtl/calc_seq.sv
// Serial calculator: A, opcode, optional B in; result + ovf/err out.
// Chained ops feed the previous result back in as operand A.
module calc_seq
  import calc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic  clk,
  input logic  rst,
  calc_if.slave bus
);

  state_t state, state_nxt;

  logic [WIDTH-1:0]   num1, num1_nxt;
  logic [WIDTH-1:0]   res, res_nxt;
  logic [3:0]         op, op_nxt;
  logic               chain, chain_nxt;
  logic               ovf_r, ovf_nxt;
  logic               err_r, err_nxt;
  logic               accept;
  logic               div_start;
  logic               div_busy, div_done;
  logic [WIDTH-1:0]   quot, rem;
  logic [WIDTH-1:0]   mul_b;
  logic [WIDTH:0]     sum, dif;
  logic [2*WIDTH-1:0] prod;

  assign bus.in_ready  = (state == S_A) || (state == S_OP) || (state == S_B);
  assign bus.out_valid = (state == S_RES);
  assign bus.out       = res;
  assign bus.ovf       = ovf_r;
  assign bus.err       = err_r;

  assign accept = bus.in_valid && bus.in_ready;

  // SQR reuses the multiplier with A on both inputs
  assign mul_b = (state == S_OP) ? num1 : bus.dataIn;
  assign sum   = {1'b0, num1} + {1'b0, bus.dataIn};
  assign dif   = {1'b0, num1} - {1'b0, bus.dataIn};
  assign prod  = {{WIDTH{1'b0}}, num1} * {{WIDTH{1'b0}}, mul_b};

  calc_div #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (num1),
    .divisor  (bus.dataIn),
    .busy     (div_busy),
    .done     (div_done),
    .quot     (quot),
    .rem      (rem)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_A;
      num1  <= '0;
      res   <= '0;
      op    <= '0;
      chain <= 1'b0;
      ovf_r <= 1'b0;
      err_r <= 1'b0;
    end else begin
      state <= state_nxt;
      num1  <= num1_nxt;
      res   <= res_nxt;
      op    <= op_nxt;
      chain <= chain_nxt;
      ovf_r <= ovf_nxt;
      err_r <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    num1_nxt  = num1;
    res_nxt   = res;
    op_nxt    = op;
    chain_nxt = chain;
    ovf_nxt   = ovf_r;
    err_nxt   = err_r;
    div_start = 1'b0;
    unique case (state)
      S_A: begin
        if (accept) begin
          num1_nxt  = bus.dataIn;
          state_nxt = S_OP;
        end
      end
      S_OP: begin
        if (accept) begin
          op_nxt    = bus.dataIn[3:0];
          chain_nxt = bus.dataIn[CHAIN_BIT];
          ovf_nxt   = 1'b0;
          err_nxt   = 1'b0;
          unique case (1'b1)
            (bus.dataIn[3:0] == OP_SQR): begin
              res_nxt   = prod[WIDTH-1:0];
              ovf_nxt   = |prod[2*WIDTH-1:WIDTH];
              state_nxt = S_RES;
            end
            (!op_legal(bus.dataIn[3:0])): begin
              res_nxt   = '0;
              err_nxt   = 1'b1;
              state_nxt = S_RES;
            end
            default: state_nxt = S_B;
          endcase
        end
      end
      S_B: begin
        if (accept) begin
          ovf_nxt   = 1'b0;
          err_nxt   = 1'b0;
          state_nxt = S_RES;
          case (op)
            OP_ADD: begin
              res_nxt = sum[WIDTH-1:0];
              ovf_nxt = sum[WIDTH];
            end
            OP_SUB: begin
              res_nxt = dif[WIDTH-1:0];
              ovf_nxt = dif[WIDTH];
            end
            OP_MUL: begin
              res_nxt = prod[WIDTH-1:0];
              ovf_nxt = |prod[2*WIDTH-1:WIDTH];
            end
            OP_AND: res_nxt = num1 & bus.dataIn;
            OP_OR:  res_nxt = num1 | bus.dataIn;
            OP_XOR: res_nxt = num1 ^ bus.dataIn;
            OP_DIV, OP_MOD: begin
              if (bus.dataIn == '0) begin
                res_nxt = '0;
                err_nxt = 1'b1;
              end else begin
                div_start = 1'b1;
                state_nxt = S_DIV;
              end
            end
            default: begin
              res_nxt = '0;
              err_nxt = 1'b1;
            end
          endcase
        end
      end
      S_DIV: begin
        if (div_done && !div_busy) begin
          res_nxt   = (op == OP_MOD) ? rem : quot;
          ovf_nxt   = 1'b0;
          err_nxt   = 1'b0;
          state_nxt = S_RES;
        end
      end
      S_RES: begin
        if (bus.out_ready) begin
          if (chain) begin
            num1_nxt  = res;
            state_nxt = S_OP;
          end else begin
            state_nxt = S_A;
          end
        end
      end
      default: state_nxt = S_A;
    endcase
  end

endmodule
